seq_divider_8: RTL and testbench

Multi-cycle unsigned 8-bit restoring divider. It sequences one shared `byte_ripple_add_sub` instance in subtract mode, performing one trial subtraction per clock over 8 iterations. It returns quotient, remainder and a divide-by-zero flag through a start/done handshake. The block is the first sequential arithmetic unit layered on the combinational adder datapath and is intended as the ALU's DIV/MOD engine.

---
 rtl/seq_divider_8.sv | 148 ++++++++++++++
 tb/tb_seq_divider_8.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8.sv
// Multi-cycle unsigned 8-bit restoring divider built around one shared ripple
// adder in subtract mode; one trial subtraction per clock, start/done handshake.
`timescale 1ns/1ps

module byte_ripple_add_sub (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       sub_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  logic [8:0] carry;
  logic [7:0] bEff;

  // Subtraction is A + ~B + 1, so carry-out high means no borrow (A >= B).
  assign bEff     = b_i ^ {8{sub_i}};
  assign carry[0] = sub_i;

  for (genvar i = 0; i < 8; i++) begin : gFullAdder
    assign sum_o[i]   = a_i[i] ^ bEff[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & bEff[i]) | (carry[i] & (a_i[i] ^ bEff[i]));
  end

  assign cout_o = carry[8];
endmodule

module seq_divider_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [7:0] d_q, d_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] quotient_q, quotient_d;
  logic [7:0] remainder_q, remainder_d;
  logic       dbz_q, dbz_d;

  logic [7:0] shifted;
  logic [7:0] diff;
  logic       carryOut;
  logic       ge;
  logic [7:0] rNext;
  logic [7:0] qNext;

  assign shifted = {r_q[6:0], q_q[7]};

  byte_ripple_add_sub uAddSub (
    .a_i    (shifted),
    .b_i    (d_q),
    .sub_i  (1'b1),
    .sum_o  (diff),
    .cout_o (carryOut)
  );

  // r_q[7] is structurally zero for 8-bit operands but kept in the compare.
  assign ge    = r_q[7] | carryOut;
  assign rNext = ge ? diff : shifted;
  assign qNext = {q_q[6:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (divisor == 8'd0) ? DONE : RUN;
      RUN:  if (cnt_q == 4'd7) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Results are written on the edge entering DONE so they are valid with done.
  always_comb begin
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start && divisor != 8'd0) begin
          r_d   = '0;
          q_d   = dividend;
          d_d   = divisor;
          cnt_d = '0;
        end else if (start) begin
          quotient_d  = 8'hFF;
          remainder_d = dividend;
          dbz_d       = 1'b1;
        end
      end
      RUN: begin
        r_d   = rNext;
        q_d   = qNext;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          quotient_d  = qNext;
          remainder_d = rNext;
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8: directed table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
`timescale 1ns/1ps

module tb_seq_divider_8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  logic [7:0] prevQ = '0;
  logic [7:0] prevR = '0;
  logic       prevZ = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  seq_divider_8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Division by zero saturates the quotient and passes the dividend through.
  task automatic refModel(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic z);
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] eq, input logic [7:0] er,
                               input logic ez, input string tag);
    int lat, busyCnt, doneCnt;
    logic [7:0] gq, gr;
    logic gz;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    lat = -1; busyCnt = 0; doneCnt = 0; gq = '0; gr = '0; gz = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1 && b != 8'd0) begin
        checkOutput({tag, " hold q"}, int'(quotient), int'(prevQ));
        checkOutput({tag, " hold z"}, int'(div_by_zero), int'(prevZ));
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (lat < 0) begin
          lat = c - 1;
          gq = quotient; gr = remainder; gz = div_by_zero;
        end
      end
    end
    checkOutput({tag, " latency"}, lat, (b == 8'd0) ? 0 : 8);
    checkOutput({tag, " busy cycles"}, busyCnt, (b == 8'd0) ? 0 : 8);
    checkOutput({tag, " done pulses"}, doneCnt, 1);
    checkOutput({tag, " quotient"}, int'(gq), int'(eq));
    checkOutput({tag, " remainder"}, int'(gr), int'(er));
    checkOutput({tag, " div_by_zero"}, int'(gz), int'(ez));
    checkOutput({tag, " held remainder"}, int'(remainder), int'(er));
    prevQ = eq; prevR = er; prevZ = ez;
  endtask

  initial begin
    int doneCnt, busyCnt;
    logic [7:0] a, b, eq, er;
    logic ez;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2, 1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0};
    vecs[2] = '{8'd200, 8'd200, 8'd1,   8'd0, 1'b0};
    vecs[3] = '{8'd3,   8'd10,  8'd0,   8'd3, 1'b0};
    vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0};
    vecs[5] = '{8'd5,   8'd0,   8'hFF,  8'd5, 1'b1};
    vecs[6] = '{8'd9,   8'd3,   8'd3,   8'd0, 1'b0};

    #1;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    checkOutput("reset div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                    $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));

    // start held high: second operand set changes mid-RUN and is taken only after DONE
    @(negedge clk);
    start = 1'b1; dividend = 8'd250; divisor = 8'd200;
    @(posedge clk);
    doneCnt = 0; busyCnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 3) begin dividend = 8'd17; divisor = 8'd4; end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) begin
          checkOutput("held first done cycle", c, 9);
          checkOutput("held first quotient", int'(quotient), 1);
          checkOutput("held first remainder", int'(remainder), 50);
        end else if (doneCnt == 2) begin
          checkOutput("held second done cycle", c, 19);
          checkOutput("held second quotient", int'(quotient), 4);
          checkOutput("held second remainder", int'(remainder), 1);
        end
      end
      if (c == 19) start = 1'b0;
    end
    checkOutput("held done pulses", doneCnt, 2);
    checkOutput("held busy cycles", busyCnt, 16);
    prevQ = 8'd4; prevR = 8'd1; prevZ = 1'b0;

    // Reset during iteration 4 of 100/7
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrun busy before reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset busy", int'(busy), 0);
    checkOutput("midrun reset done", int'(done), 0);
    checkOutput("midrun reset quotient", int'(quotient), 0);
    checkOutput("midrun reset remainder", int'(remainder), 0);
    checkOutput("midrun reset div_by_zero", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("midrun no done after reset", doneCnt, 0);
    prevQ = '0; prevR = '0; prevZ = 1'b0;
    applyStimulus(8'd64, 8'd8, 8'd8, 8'd0, 1'b0, "after reset 64/8");

    // Randomized operands, biased towards zero and small divisors
    for (int n = 0; n < 1200; n++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 8'd0;
        1, 2:    b = 8'($urandom_range(1, 15));
        default: b = 8'($urandom);
      endcase
      refModel(a, b, eq, er, ez);
      applyStimulus(a, b, eq, er, ez, $sformatf("rand %0d/%0d", a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
